memn2n_phase_sequencer: RTL and testbench
=========================================

Name: memn2n_phase_sequencer

Overview:
- Parametrised, multi-hop successor to the MemN2N forward-pass phase controller.
- Sequences NUM_PHASE phases, phase 0 = IDLE, phase NUM_PHASE-1 = END_FWD.
- Adds: per-phase auto-advance mask, configurable hop loop over a phase range, start/done handshake, one-hot plus index outputs, and a per-phase timeout watchdog.
- Sits between the top-level AXI control registers and the datapath units that return done_phase.

Parameters:
- NUM_PHASE, 10, number of phases including IDLE (0) and END_FWD (NUM_PHASE-1); minimum 4.
- BW_PHASE, $clog2(NUM_PHASE), width of phase index.
- BW_HOP, 3, width of hop count and configuration.
- BW_TIMEOUT, 16, width of the per-phase cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  level; low forces IDLE
- start  in  1  pulse; begins one forward pass from IDLE
- done_phase  in  1  current phase complete (from datapath)
- auto_adv_mask  in  NUM_PHASE  bit p=1: phase p lasts exactly one cycle, ignores done_phase
- num_hop  in  BW_HOP  hops to execute; 0 treated as 1
- loop_first  in  BW_PHASE  first phase index of hop loop
- loop_last  in  BW_PHASE  last phase index of hop loop
- timeout_limit  in  BW_TIMEOUT  max cycles in a waiting phase; 0 = disabled
- memn2n_phase  out  NUM_PHASE  one-hot current phase
- phase_idx  out  BW_PHASE  binary current phase
- hop_cnt  out  BW_HOP  current hop, 0-based
- phase_start  out  1  pulse, first cycle of every phase entry (including loop re-entry)
- busy  out  1  high when phase != IDLE
- done_fwd  out  1  one-cycle pulse on END_FWD -> IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at clk edge): phase_idx=0, memn2n_phase=1, hop_cnt=0, counter=0, phase_start=0, busy=0, done_fwd=0, timeout_err=0. Reset overrides all other inputs.
- All outputs are registered. A qualifying condition sampled at edge t is visible after edge t+1.
- IDLE: if enable & start, go to phase 1, hop_cnt=0, clear timeout_err, phase_start=1.
  - At this edge, latch auto_adv_mask, num_hop, loop_first, loop_last and timeout_limit into shadow registers. Input changes mid-pass have no effect.
  - done_phase is ignored in IDLE.
- Phase p, 1 <= p < NUM_PHASE-1: advances when adv = shadow_mask[p] | done_phase.
  - If p == loop_last, loop is valid and hop_cnt < eff_hop-1: next = loop_first, hop_cnt+1.
  - Otherwise next = p+1; hop_cnt is unchanged.
  - eff_hop = max(num_hop, 1).
  - Loop is valid iff 1 <= loop_first <= loop_last < NUM_PHASE-1. An invalid loop means a linear pass with hop_cnt held at 0.
- END_FWD: always one cycle. Next state is IDLE with done_fwd=1 for exactly one cycle and hop_cnt reset to 0.
- start while busy is ignored. Extra done_phase pulses are consumed only by the current phase.
- phase_start=1 on the cycle after any transition into a non-IDLE phase. This includes a self-loop when loop_first == loop_last.
- Watchdog: counter clears on every phase entry and increments each cycle in a phase with shadow_mask[p]=0 and done_phase=0.
  - If shadow_timeout != 0 and counter == shadow_timeout-1 with no done_phase, next state is IDLE: timeout_err=1, hop_cnt=0, done_fwd=0.
  - done_phase in the same cycle as expiry wins: normal advance, no error.
- enable=0 at any edge (and rst=0): next state is IDLE, hop_cnt=0, counter=0, no done_fwd. timeout_err is held.
- memn2n_phase is always exactly one-hot and equal to 1 << phase_idx.

Test Plan:
- Defaults: mask with bits 1, 6, 9 set, num_hop=1, loop 2..5, done_phase pulsed 3 cycles after each waiting-phase entry -> phase_idx sequence 0,1,2..5,6,7,8,9,0; done_fwd high exactly 1 cycle; hop_cnt=0 throughout.
- Multi-hop: num_hop=3, loop_first=2, loop_last=5, done_phase tied high -> phases 1,2,3,4,5,2,3,4,5,2,3,4,5,6,7,8,9,0 on consecutive cycles; hop_cnt 0,1,2 at each entry to phase 2; 12 phase_start pulses before phase 6.
- Timeout: timeout_limit=8, done_phase never asserted in phase 2 -> IDLE exactly 8 cycles after entry to phase 2; timeout_err=1 and held; next start clears it.
- Abort: enable dropped while in phase 4 of hop 1 -> IDLE next cycle, hop_cnt=0, busy=0, no done_fwd; start with enable=1 re-runs from phase 1.
- Edge configs: num_hop=0 and loop_first=6 > loop_last=3 -> linear single pass. loop_first=loop_last=3 with num_hop=2 -> phase 3 entered twice with phase_start pulsed each time.
- Config isolation: change num_hop from 2 to 5 and toggle start mid-pass -> pass completes with 2 hops; start while busy is ignored.

Source files
------------

// File: rtl/memn2n_phase_sequencer.sv
// Multi-hop MemN2N forward-pass phase sequencer: walks phases 1..NUM_PHASE-1,
// optionally looping over a phase range, with auto-advance mask and watchdog.
//
// state (phase_idx)        | meaning
// 0            IDLE        | waiting for enable & start; config shadows latched on exit
// 1..N-2       RUN         | advance on shadow_mask[p] | done_phase, hop loop at loop_last
// N-1          END_FWD     | single cycle, returns to IDLE with done_fwd
module memn2n_phase_sequencer #(
   parameter int NUM_PHASE  = 10,
   parameter int BW_PHASE   = $clog2(NUM_PHASE),
   parameter int BW_HOP     = 3,
   parameter int BW_TIMEOUT = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  start_i,
   input  logic                  done_phase_i,
   input  logic [NUM_PHASE-1:0]  auto_adv_mask_i,
   input  logic [BW_HOP-1:0]     num_hop_i,
   input  logic [BW_PHASE-1:0]   loop_first_i,
   input  logic [BW_PHASE-1:0]   loop_last_i,
   input  logic [BW_TIMEOUT-1:0] timeout_limit_i,
   output logic [NUM_PHASE-1:0]  memn2n_phase_o,
   output logic [BW_PHASE-1:0]   phase_idx_o,
   output logic [BW_HOP-1:0]     hop_cnt_o,
   output logic                  phase_start_o,
   output logic                  busy_o,
   output logic                  done_fwd_o,
   output logic                  timeout_err_o
);

   localparam logic [BW_PHASE-1:0] END_IDX = BW_PHASE'(NUM_PHASE - 1);

   typedef enum logic [1:0] {K_IDLE, K_RUN, K_END} kind_e;

   logic [BW_PHASE-1:0]   phase_q, phase_d;
   logic [NUM_PHASE-1:0]  onehot_q, onehot_d;
   logic [BW_HOP-1:0]     hop_q, hop_d;
   logic [BW_TIMEOUT-1:0] cnt_q, cnt_d;
   logic                  ps_q, ps_d;
   logic                  busy_q, busy_d;
   logic                  dfwd_q, dfwd_d;
   logic                  terr_q, terr_d;
   logic [NUM_PHASE-1:0]  mask_q, mask_d;
   logic [BW_HOP-1:0]     nhop_q, nhop_d;
   logic [BW_PHASE-1:0]   first_q, first_d;
   logic [BW_PHASE-1:0]   last_q, last_d;
   logic [BW_TIMEOUT-1:0] tmo_q, tmo_d;

   kind_e               kind;
   logic [BW_HOP-1:0]   eff_hop;
   logic                loop_ok;
   logic                adv;
   logic                loop_back;
   logic                expire;

   always_comb begin
      if (phase_q == '0)
         kind = K_IDLE;
      else if (phase_q == END_IDX)
         kind = K_END;
      else
         kind = K_RUN;
   end

   assign eff_hop   = (nhop_q == '0) ? BW_HOP'(1) : nhop_q;
   assign loop_ok   = (first_q != '0) && (first_q <= last_q) && (last_q < END_IDX);
   assign adv       = mask_q[phase_q] | done_phase_i;
   assign loop_back = (phase_q == last_q) && loop_ok && (hop_q < eff_hop - BW_HOP'(1));
   // done_phase in the expiry cycle takes priority because adv is tested first
   assign expire    = (tmo_q != '0) && (cnt_q == tmo_q - BW_TIMEOUT'(1));

   always_comb begin
      phase_d = phase_q;
      hop_d   = hop_q;
      cnt_d   = cnt_q;
      ps_d    = 1'b0;
      dfwd_d  = 1'b0;
      terr_d  = terr_q;
      mask_d  = mask_q;
      nhop_d  = nhop_q;
      first_d = first_q;
      last_d  = last_q;
      tmo_d   = tmo_q;

      if (!enable_i) begin
         phase_d = '0;
         hop_d   = '0;
         cnt_d   = '0;
      end else begin
         case (kind)
            K_IDLE: begin
               cnt_d = '0;
               if (start_i) begin
                  phase_d = BW_PHASE'(1);
                  hop_d   = '0;
                  terr_d  = 1'b0;
                  ps_d    = 1'b1;
                  mask_d  = auto_adv_mask_i;
                  nhop_d  = num_hop_i;
                  first_d = loop_first_i;
                  last_d  = loop_last_i;
                  tmo_d   = timeout_limit_i;
               end
            end
            K_END: begin
               phase_d = '0;
               hop_d   = '0;
               cnt_d   = '0;
               dfwd_d  = 1'b1;
            end
            default: begin
               if (adv) begin
                  ps_d  = 1'b1;
                  cnt_d = '0;
                  if (loop_back) begin
                     phase_d = first_q;
                     hop_d   = hop_q + BW_HOP'(1);
                  end else begin
                     phase_d = phase_q + BW_PHASE'(1);
                  end
               end else if (expire) begin
                  phase_d = '0;
                  hop_d   = '0;
                  cnt_d   = '0;
                  terr_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + BW_TIMEOUT'(1);
               end
            end
         endcase
      end

      onehot_d = NUM_PHASE'(1) << phase_d;
      busy_d   = (phase_d != '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q  <= '0;
         onehot_q <= NUM_PHASE'(1);
         hop_q    <= '0;
         cnt_q    <= '0;
         ps_q     <= 1'b0;
         busy_q   <= 1'b0;
         dfwd_q   <= 1'b0;
         terr_q   <= 1'b0;
         mask_q   <= '0;
         nhop_q   <= '0;
         first_q  <= '0;
         last_q   <= '0;
         tmo_q    <= '0;
      end else begin
         phase_q  <= phase_d;
         onehot_q <= onehot_d;
         hop_q    <= hop_d;
         cnt_q    <= cnt_d;
         ps_q     <= ps_d;
         busy_q   <= busy_d;
         dfwd_q   <= dfwd_d;
         terr_q   <= terr_d;
         mask_q   <= mask_d;
         nhop_q   <= nhop_d;
         first_q  <= first_d;
         last_q   <= last_d;
         tmo_q    <= tmo_d;
      end
   end

   assign memn2n_phase_o = onehot_q;
   assign phase_idx_o    = phase_q;
   assign hop_cnt_o      = hop_q;
   assign phase_start_o  = ps_q;
   assign busy_o         = busy_q;
   assign done_fwd_o     = dfwd_q;
   assign timeout_err_o  = terr_q;

endmodule

// File: tb/tb_memn2n_phase_sequencer.sv
// Directed bench for memn2n_phase_sequencer: linear, multi-hop, timeout, abort,
// edge loop configs and config isolation, all with hand-derived phase traces.
module tb_memn2n_phase_sequencer;

   localparam int NUM_PHASE  = 10;
   localparam int BW_PHASE   = 4;
   localparam int BW_HOP     = 3;
   localparam int BW_TIMEOUT = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  enable;
   logic                  start;
   logic                  done_phase;
   logic [NUM_PHASE-1:0]  mask;
   logic [BW_HOP-1:0]     num_hop;
   logic [BW_PHASE-1:0]   loop_first;
   logic [BW_PHASE-1:0]   loop_last;
   logic [BW_TIMEOUT-1:0] tmo;
   logic [NUM_PHASE-1:0]  onehot;
   logic [BW_PHASE-1:0]   pidx;
   logic [BW_HOP-1:0]     hop;
   logic                  pstart;
   logic                  busy;
   logic                  dfwd;
   logic                  terr;

   int  checks   = 0;
   int  failures = 0;
   int  ps_count = 0;
   bit  done_tie = 1'b0;

   always #5 clk = ~clk;

   memn2n_phase_sequencer #(
      .NUM_PHASE (NUM_PHASE),
      .BW_PHASE  (BW_PHASE),
      .BW_HOP    (BW_HOP),
      .BW_TIMEOUT(BW_TIMEOUT)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable),
      .start_i        (start),
      .done_phase_i   (done_phase),
      .auto_adv_mask_i(mask),
      .num_hop_i      (num_hop),
      .loop_first_i   (loop_first),
      .loop_last_i    (loop_last),
      .timeout_limit_i(tmo),
      .memn2n_phase_o (onehot),
      .phase_idx_o    (pidx),
      .hop_cnt_o      (hop),
      .phase_start_o  (pstart),
      .busy_o         (busy),
      .done_fwd_o     (dfwd),
      .timeout_err_o  (terr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stays in phase p for ncyc cycles; done_phase raised on the last one if use_done.
   task automatic expect_phase(input int p, input int h, input int ncyc, input bit use_done);
      for (int i = 0; i < ncyc; i++) begin
         chk($sformatf("phase_idx p%0d c%0d", p, i), 32'(pidx), 32'(p));
         chk($sformatf("onehot p%0d c%0d", p, i), 32'(onehot), 32'(1) << p);
         chk($sformatf("hop p%0d c%0d", p, i), 32'(hop), 32'(h));
         chk($sformatf("phase_start p%0d c%0d", p, i), 32'(pstart), (i == 0) ? 32'd1 : 32'd0);
         chk($sformatf("busy p%0d", p), 32'(busy), 32'd1);
         chk($sformatf("done_fwd p%0d", p), 32'(dfwd), 32'd0);
         if (pstart) ps_count++;
         done_phase = done_tie | (use_done && (i == ncyc - 1));
         tick();
         done_phase = done_tie;
      end
   endtask

   task automatic expect_idle(input string tag, input bit exp_dfwd, input bit exp_terr);
      chk({tag, " phase_idx"}, 32'(pidx), 32'd0);
      chk({tag, " onehot"}, 32'(onehot), 32'd1);
      chk({tag, " hop"}, 32'(hop), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " phase_start"}, 32'(pstart), 32'd0);
      chk({tag, " done_fwd"}, 32'(dfwd), 32'(exp_dfwd));
      chk({tag, " timeout_err"}, 32'(terr), 32'(exp_terr));
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; enable = 1'b1; start = 1'b1; done_phase = 1'b1;
      mask = 10'h242; num_hop = 3'd1; loop_first = 4'd2; loop_last = 4'd5; tmo = '0;
      tick(); tick();
      expect_idle("reset", 1'b0, 1'b0);
      rst = 1'b0; start = 1'b0; done_phase = 1'b0;
      tick();
      expect_idle("post_reset", 1'b0, 1'b0);

      // defaults: linear pass, done 3 cycles into each waiting phase
      do_start();
      expect_phase(1, 0, 1, 1'b0);
      for (int p = 2; p <= 5; p++) expect_phase(p, 0, 3, 1'b1);
      expect_phase(6, 0, 1, 1'b0);
      expect_phase(7, 0, 3, 1'b1);
      expect_phase(8, 0, 3, 1'b1);
      expect_phase(9, 0, 1, 1'b0);
      expect_idle("t1_end", 1'b1, 1'b0);
      tick();
      expect_idle("t1_after", 1'b0, 1'b0);

      // multi-hop, done tied high
      num_hop = 3'd3; done_tie = 1'b1; done_phase = 1'b1;
      do_start();
      expect_phase(1, 0, 1, 1'b0);
      ps_count = 0;
      for (int h = 0; h < 3; h++)
         for (int p = 2; p <= 5; p++) expect_phase(p, h, 1, 1'b0);
      chk("t2 ps_count", 32'(ps_count), 32'd12);
      for (int p = 6; p <= 9; p++) expect_phase(p, 2, 1, 1'b0);
      expect_idle("t2_end", 1'b1, 1'b0);
      done_tie = 1'b0; done_phase = 1'b0;
      tick();

      // timeout in phase 2 after 8 cycles
      num_hop = 3'd1; tmo = 16'd8;
      do_start();
      expect_phase(1, 0, 1, 1'b0);
      expect_phase(2, 0, 8, 1'b0);
      expect_idle("t3_expire", 1'b0, 1'b1);
      tick();
      expect_idle("t3_held", 1'b0, 1'b1);
      enable = 1'b0;
      tick();
      expect_idle("t3_disable_held", 1'b0, 1'b1);
      enable = 1'b1;
      do_start();
      chk("t3 terr cleared", 32'(terr), 32'd0);
      expect_phase(1, 0, 1, 1'b0);
      // done on the expiry cycle wins
      expect_phase(2, 0, 8, 1'b1);
      chk("t3 done_wins phase", 32'(pidx), 32'd3);
      chk("t3 done_wins terr", 32'(terr), 32'd0);
      enable = 1'b0;
      tick();
      expect_idle("t3_abort", 1'b0, 1'b0);
      enable = 1'b1; tmo = '0;

      // abort in phase 4 of hop 1
      num_hop = 3'd2; done_tie = 1'b1; done_phase = 1'b1;
      do_start();
      expect_phase(1, 0, 1, 1'b0);
      for (int p = 2; p <= 5; p++) expect_phase(p, 0, 1, 1'b0);
      expect_phase(2, 1, 1, 1'b0);
      expect_phase(3, 1, 1, 1'b0);
      chk("t4 pre_abort phase", 32'(pidx), 32'd4);
      chk("t4 pre_abort hop", 32'(hop), 32'd1);
      enable = 1'b0;
      tick();
      expect_idle("t4_abort", 1'b0, 1'b0);
      enable = 1'b1;
      do_start();
      expect_phase(1, 0, 1, 1'b0);
      enable = 1'b0;
      tick();
      expect_idle("t4_abort2", 1'b0, 1'b0);
      enable = 1'b1;

      // num_hop=0 and inverted loop range: single linear pass
      num_hop = 3'd0; loop_first = 4'd6; loop_last = 4'd3;
      do_start();
      for (int p = 1; p <= 9; p++) expect_phase(p, 0, 1, 1'b0);
      expect_idle("t5a_end", 1'b1, 1'b0);

      // self-loop on phase 3
      num_hop = 3'd2; loop_first = 4'd3; loop_last = 4'd3;
      do_start();
      expect_phase(1, 0, 1, 1'b0);
      expect_phase(2, 0, 1, 1'b0);
      expect_phase(3, 0, 1, 1'b0);
      expect_phase(3, 1, 1, 1'b0);
      for (int p = 4; p <= 9; p++) expect_phase(p, 1, 1, 1'b0);
      expect_idle("t5b_end", 1'b1, 1'b0);

      // config changes and start mid-pass are ignored
      num_hop = 3'd2; loop_first = 4'd2; loop_last = 4'd5;
      do_start();
      expect_phase(1, 0, 1, 1'b0);
      num_hop = 3'd5; loop_first = 4'd1; start = 1'b1;
      for (int p = 2; p <= 5; p++) expect_phase(p, 0, 1, 1'b0);
      start = 1'b0;
      for (int p = 2; p <= 5; p++) expect_phase(p, 1, 1, 1'b0);
      for (int p = 6; p <= 9; p++) expect_phase(p, 1, 1, 1'b0);
      expect_idle("t6_end", 1'b1, 1'b0);
      done_tie = 1'b0; done_phase = 1'b0;
      tick();
      expect_idle("t6_after", 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
